mem_access_unit: RTL and testbench

//  MEM-stage load/store controller placed directly upstream of data_ram256x32; it owns the RAM's Enable/ReadWrite/Address/DataIn.

---
 rtl/mem_access_pkg.sv | 42 ++++
 rtl/mem_access_if.sv | 34 +++
 rtl/mem_lane_align.sv | 39 +++
 rtl/mem_access_unit.sv | 139 +++++++++++++
 tb/tb_mem_access_unit.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types for the MEM-stage load/store controller: access sizes, FSM states,
// RAM direction encodings and the address alignment helpers.
package mem_access_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_e;

  localparam logic RAM_READ  = 1'b1;
  localparam logic RAM_WRITE = 1'b0;

  function automatic logic is_misaligned(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] force_align(size_e sz, logic [1:0] lo);
    case (sz)
      SZ_HALF: return {lo[1], 1'b0};
      SZ_WORD: return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Request/response handshake from the EX/MEM latch plus the word-wide RAM port.
// master = pipeline + RAM side, slave = mem_access_unit.
interface mem_access_if #(
  parameter int ADDR_W = 8
);
  import mem_access_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              ram_en;
  logic              ram_rw;
  logic [ADDR_W-3:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, ram_en, ram_rw, ram_addr, ram_wdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, ram_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err, ram_en, ram_rw, ram_addr, ram_wdata
  );

endinterface

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering: load extract + zero/sign extend, and the
// store merge used by read-modify-write. Purely combinational.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [1:0]        addr_lo_i,
  input  size_e             size_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merged_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    load_o   = rdata_i;
    merged_o = wdata_i;
    case (size_i)
      SZ_BYTE: begin
        load_o   = {{24{signed_i & byte_sel[7]}}, byte_sel};
        merged_o = rdata_i;
        merged_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        load_o   = {{16{signed_i & half_sel[15]}}, half_sel};
        merged_o = rdata_i;
        if (addr_lo_i[1]) merged_o[31:16] = wdata_i[15:0];
        else              merged_o[15:0]  = wdata_i[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller in front of a 32-bit word RAM; sub-word stores
// become read-modify-write. Define MEM_ALIGN_CHECK_EN to trap misaligned half/word accesses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         reset,
  mem_access_if.slave  bus
);

  state_e            state_q, state_d;
  size_e             size_q, size_d;
  logic              signed_q, signed_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] merge_q, merge_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged_data;
  size_e             req_size;
  logic              req_bad;

  assign req_size = size_e'(bus.req_size);

  mem_lane_align u_align (
    .addr_lo_i (addr_q[1:0]),
    .size_i    (size_q),
    .signed_i  (signed_q),
    .rdata_i   (bus.ram_rdata),
    .wdata_i   (wdata_q),
    .load_o    (load_data),
    .merged_o  (merged_data)
  );

`ifdef MEM_ALIGN_CHECK_EN
  assign req_bad = (req_size == SZ_RSVD) || is_misaligned(req_size, bus.req_addr[1:0]);
`else
  assign req_bad = (req_size == SZ_RSVD);
`endif

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    state_d        = state_q;
    size_d         = size_q;
    signed_d       = signed_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    merge_d        = merge_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.ram_en     = 1'b0;
    bus.ram_rw     = RAM_READ;
    bus.ram_addr   = '0;
    bus.ram_wdata  = '0;

    case (state_q)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          size_d   = req_size;
          signed_d = bus.req_signed;
          addr_d   = {bus.req_addr[ADDR_W-1:2], force_align(req_size, bus.req_addr[1:0])};
          wdata_d  = bus.req_wdata;
          rdata_d  = '0;
          err_d    = req_bad;
          if (req_bad)                   state_d = S_DONE;
          else if (!bus.req_write)       state_d = S_RD;
          else if (req_size == SZ_WORD)  state_d = S_WR;
          else                           state_d = S_RMW_RD;
        end
      end
      S_RD: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = addr_q[ADDR_W-1:2];
        rdata_d      = load_data;
        state_d      = S_DONE;
      end
      S_WR: begin
        bus.ram_en    = 1'b1;
        bus.ram_rw    = RAM_WRITE;
        bus.ram_addr  = addr_q[ADDR_W-1:2];
        bus.ram_wdata = wdata_q;
        state_d       = S_DONE;
      end
      S_RMW_RD: begin
        bus.ram_en   = 1'b1;
        bus.ram_addr = addr_q[ADDR_W-1:2];
        merge_d      = merged_data;
        state_d      = S_RMW_WR;
      end
      // The RAM is only written here, so an aborted RMW never disturbs memory.
      S_RMW_WR: begin
        bus.ram_en    = 1'b1;
        bus.ram_rw    = RAM_WRITE;
        bus.ram_addr  = addr_q[ADDR_W-1:2];
        bus.ram_wdata = merge_q;
        state_d       = S_DONE;
      end
      S_DONE: begin
        bus.resp_valid = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      size_q   <= SZ_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
      state_q  <= state_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      merge_q  <= merge_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit driving a behavioural 64x32 word RAM
// (combinational read, clocked write) with a fixed preload.
module tb_mem_access_unit;

  logic clk;
  logic reset;
  logic ram_init;

  int checks   = 0;
  int failures = 0;

  mem_access_if #(.ADDR_W(8)) bus ();

  mem_access_unit #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [64];
  int          wr_cnt;
  int          en_cnt;

  function automatic logic [31:0] init_word(int i);
    logic [7:0] lo;
    lo = i[7:0];
    case (i)
      0:       return 32'h1122_3344;
      1:       return 32'h8899_AABB;
      2:       return 32'hDEAD_BEEF;
      default: return {24'hA5A5A5, lo};
    endcase
  endfunction

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      wr_cnt <= 0;
      en_cnt <= 0;
    end else begin
      if (bus.ram_en) en_cnt <= en_cnt + 1;
      if (bus.ram_en && !bus.ram_rw) begin
        mem[bus.ram_addr] <= bus.ram_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  assign bus.ram_rdata = mem[bus.ram_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request from IDLE, measures accept-to-resp_valid latency, returns in IDLE.
  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [7:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] rd, output logic er,
                         output int wrs, output int ens);
    int w0, e0;
    w0 = wr_cnt;
    e0 = en_cnt;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.resp_rdata;
    er = bus.resp_err;
    @(posedge clk); #1;
    wrs = wr_cnt - w0;
    ens = en_cnt - e0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, wrs, ens, w0;
    logic [31:0] rd;
    logic        er;

    reset          = 1'b1;
    ram_init       = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b00;
    bus.req_signed = 1'b0;
    bus.req_addr   = 8'h00;
    bus.req_wdata  = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    ram_init = 1'b0;

    check("rst_req_ready",  bus.req_ready,  1);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_err",   bus.resp_err,   0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_ram_en",     bus.ram_en,     0);
    check("rst_ram_rw",     bus.ram_rw,     1);
    check("rst_ram_addr",   bus.ram_addr,   0);
    check("rst_ram_wdata",  bus.ram_wdata,  0);

    reset = 1'b0;
    @(posedge clk); #1;

    run_req(0, 2'b10, 0, 8'h08, 32'h0, lat, rd, er, wrs, ens);
    check("lw08_lat",   lat, 2);
    check("lw08_rdata", rd,  32'hDEAD_BEEF);
    check("lw08_err",   er,  0);
    check("lw08_writes", wrs, 0);

    run_req(0, 2'b00, 1, 8'h0B, 32'h0, lat, rd, er, wrs, ens);
    check("lb0B_s", rd, 32'hFFFF_FFDE);
    run_req(0, 2'b00, 0, 8'h0B, 32'h0, lat, rd, er, wrs, ens);
    check("lb0B_u", rd, 32'h0000_00DE);
    run_req(0, 2'b00, 0, 8'h09, 32'h0, lat, rd, er, wrs, ens);
    check("lb09_u", rd, 32'h0000_00BE);
    run_req(0, 2'b01, 1, 8'h0A, 32'h0, lat, rd, er, wrs, ens);
    check("lh0A_s", rd, 32'hFFFF_DEAD);
    run_req(0, 2'b01, 0, 8'h08, 32'h0, lat, rd, er, wrs, ens);
    check("lh08_u", rd, 32'h0000_BEEF);
    check("lh08_lat", lat, 2);

    run_req(1, 2'b00, 0, 8'h09, 32'hFFFF_FF5A, lat, rd, er, wrs, ens);
    check("sb09_lat",    lat,    3);
    check("sb09_writes", wrs,    1);
    check("sb09_rdata",  rd,     0);
    check("sb09_err",    er,     0);
    check("sb09_mem",    mem[2], 32'hDEAD_5AEF);

    run_req(1, 2'b01, 0, 8'h06, 32'hFFFF_1234, lat, rd, er, wrs, ens);
    check("sh06_lat",    lat,    3);
    check("sh06_writes", wrs,    1);
    check("sh06_mem",    mem[1], 32'h1234_AABB);

    run_req(1, 2'b10, 0, 8'hFC, 32'hCAFE_F00D, lat, rd, er, wrs, ens);
    check("swFC_lat",    lat,     2);
    check("swFC_writes", wrs,     1);
    check("swFC_mem",    mem[63], 32'hCAFE_F00D);
    check("swFC_nowrap", mem[0],  32'h1122_3344);
    run_req(0, 2'b00, 1, 8'hFF, 32'h0, lat, rd, er, wrs, ens);
    check("lbFF_s", rd, 32'hFFFF_FFCA);

    run_req(0, 2'b11, 0, 8'h08, 32'h0, lat, rd, er, wrs, ens);
    check("rsvd_ld_lat",   lat, 1);
    check("rsvd_ld_err",   er,  1);
    check("rsvd_ld_rdata", rd,  0);
    check("rsvd_ld_ramen", ens, 0);
    run_req(1, 2'b11, 0, 8'h04, 32'h1111_1111, lat, rd, er, wrs, ens);
    check("rsvd_st_err",   er,     1);
    check("rsvd_st_ramen", ens,    0);
    check("rsvd_st_mem",   mem[1], 32'h1234_AABB);

    run_req(1, 2'b01, 0, 8'h05, 32'h0000_7788, lat, rd, er, wrs, ens);
`ifdef MEM_ALIGN_CHECK_EN
    check("sh05_lat",   lat,    1);
    check("sh05_err",   er,     1);
    check("sh05_ramen", ens,    0);
    check("sh05_mem",   mem[1], 32'h1234_AABB);
`else
    check("sh05_lat",    lat,    3);
    check("sh05_err",    er,     0);
    check("sh05_writes", wrs,    1);
    check("sh05_mem",    mem[1], 32'h1234_7788);
`endif

    run_req(0, 2'b10, 0, 8'h0A, 32'h0, lat, rd, er, wrs, ens);
`ifdef MEM_ALIGN_CHECK_EN
    check("lw0A_err",   er,  1);
    check("lw0A_rdata", rd,  0);
    check("lw0A_lat",   lat, 1);
`else
    check("lw0A_err",   er,  0);
    check("lw0A_rdata", rd,  32'hDEAD_5AEF);
    check("lw0A_lat",   lat, 2);
`endif

    // Back-to-back loads with req_valid held high.
    bus.req_write  = 1'b0;
    bus.req_size   = 2'b10;
    bus.req_signed = 1'b0;
    bus.req_addr   = 8'h00;
    bus.req_valid  = 1'b1;
    check("b2b_ready_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    check("b2b_ready_rd",  bus.req_ready,  0);
    check("b2b_valid_rd",  bus.resp_valid, 0);
    @(posedge clk); #1;
    check("b2b_valid_done1", bus.resp_valid, 1);
    check("b2b_ready_done1", bus.req_ready,  0);
    check("b2b_rdata1",      bus.resp_rdata, 32'h1122_3344);
    @(posedge clk); #1;
    check("b2b_ready_idle2", bus.req_ready,  1);
    check("b2b_valid_idle2", bus.resp_valid, 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("b2b_ready_rd2", bus.req_ready, 0);
    @(posedge clk); #1;
    check("b2b_valid_done2", bus.resp_valid, 1);
    check("b2b_rdata2",      bus.resp_rdata, 32'h1122_3344);
    @(posedge clk); #1;

    // Reset asserted while the RMW is in its read phase.
    w0 = wr_cnt;
    bus.req_write  = 1'b1;
    bus.req_size   = 2'b00;
    bus.req_addr   = 8'h00;
    bus.req_wdata  = 32'h0000_0077;
    bus.req_valid  = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    check("rmw_rd_ram_en", bus.ram_en, 1);
    check("rmw_rd_ram_rw", bus.ram_rw, 1);
    reset = 1'b1;
    #1;
    check("abort_ram_en",    bus.ram_en,    0);
    check("abort_req_ready", bus.req_ready, 1);
    @(posedge clk); #1;
    check("abort_ram_en_edge", bus.ram_en,     0);
    check("abort_ram_rw",      bus.ram_rw,     1);
    check("abort_ram_addr",    bus.ram_addr,   0);
    check("abort_ram_wdata",   bus.ram_wdata,  0);
    check("abort_resp_valid",  bus.resp_valid, 0);
    check("abort_resp_err",    bus.resp_err,   0);
    check("abort_resp_rdata",  bus.resp_rdata, 0);
    check("abort_writes",      wr_cnt - w0,    0);
    check("abort_mem",         mem[0],         32'h1122_3344);
    reset = 1'b0;
    @(posedge clk); #1;

    run_req(0, 2'b10, 0, 8'h00, 32'h0, lat, rd, er, wrs, ens);
    check("post_rst_lat",   lat, 2);
    check("post_rst_rdata", rd,  32'h1122_3344);
    check("post_rst_err",   er,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
